pwm_slew_driver: RTL and testbench
==================================

PWM_SLEW_DRIVER -- requirements
Module: pwm_slew_driver

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clocks per PWM counter step (range 1..255).
REQ-002 The block SHALL have parameter MAX_STEP, default 8, meaning the maximum duty change per PWM period (range 1..255).
REQ-003 The block SHALL have parameter DEADBAND, default 4, meaning samples below this value are treated as 0.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, meaning PWM periods without a sample before the block enters safe shutdown (range 1..255).
REQ-005 clk  input  1  single system clock; all logic on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  run enable.
REQ-008 sample_in  input  8  filtered setpoint sample from the upstream Kalman/I2C stage.
REQ-009 sample_valid  input  1  one-cycle strobe qualifying sample_in.
REQ-010 pwm_out  output  1  registered PWM drive.
REQ-011 duty  output  8  current applied duty.
REQ-012 at_target  output  1  high when duty equals target.
REQ-013 timeout  output  1  high while in TIMEOUT state.

Function
REQ-014 Prescaler: div_cnt SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be asserted in the cycle where div_cnt==CLK_DIV-1.
REQ-015 PWM counter: pwm_cnt (8 bit) SHALL increment on tick and wrap 255->0; period boundary (pb) SHALL be tick with pwm_cnt==255, giving a period of 256*CLK_DIV clocks.
REQ-016 pwm_out SHALL be registered as (pwm_cnt < duty), one clock of latency; duty=0 gives constant low, duty=255 gives 255/256 high.
REQ-017 Target capture: on sample_valid in RUN or TIMEOUT, target SHALL load 0 if sample_in < DEADBAND, else sample_in; sample_valid in IDLE SHALL be ignored.
REQ-018 Slew: at each pb, duty SHALL move toward the effective target by min(|target-duty|, MAX_STEP); duty SHALL change at no other time, and the arithmetic SHALL not overflow past 255 or underflow below 0.
REQ-019 If sample_valid and pb occur in the same cycle, the slew SHALL use the previous target; the new target SHALL apply from the next pb.
REQ-020 FSM states SHALL be IDLE, RUN, and TIMEOUT.
REQ-021 IDLE->RUN SHALL occur when enable=1. In IDLE, duty, target, wd_cnt, and the counters SHALL be held at 0.
REQ-022 RUN or TIMEOUT->IDLE SHALL occur when enable=0, immediately (next clock), with duty forced to 0 and no ramp-down.
REQ-023 Watchdog: in RUN, wd_cnt SHALL increment at each pb and clear on sample_valid; when sample_valid coincides with pb, the clear SHALL win.
REQ-024 RUN->TIMEOUT SHALL occur at the pb where wd_cnt would reach TIMEOUT.
REQ-025 In TIMEOUT, the effective target SHALL be 0, so duty ramps down by MAX_STEP per period.
REQ-026 TIMEOUT->RUN SHALL occur on sample_valid, which captures target per REQ-017 and clears wd_cnt.
REQ-027 at_target SHALL be combinational (duty == effective target); timeout SHALL be high exactly when the state is TIMEOUT.

Reset
REQ-028 While rst=1 at a clock edge, the following SHALL be cleared: state=IDLE, div_cnt=0, pwm_cnt=0, duty=0, target=0, wd_cnt=0, pwm_out=0, and timeout=0.
REQ-029 After reset, at_target SHALL read 1.
REQ-030 Reset asserted mid-ramp or mid-period SHALL take effect on the next edge with no partial pulse afterwards.
REQ-031 The first tick after reset release SHALL occur CLK_DIV clocks after enable is sampled high.

Verification (CLK_DIV=1, MAX_STEP=8, DEADBAND=4, TIMEOUT=4)
REQ-032 Ramp-up: enable=1, sample 100 -> duty 8, 16, ..., 96, then 100 at successive pbs (13 periods); at_target is high after the 13th pb; pwm_out is high for exactly duty clocks per period.
REQ-033 Deadband and ramp-down: from duty=100, sample 3 -> target 0; duty falls 92, 84, ..., 4, 0; sample 4 -> target 4.
REQ-034 Simultaneous events: sample 200 driven in the pb cycle with target=100 and duty=100 -> duty stays 100 at that pb and reaches 108 at the next pb; wd_cnt=0.
REQ-035 Watchdog: duty=40 with no samples -> timeout rises at the 4th pb; duty then falls 32, 24, 16, 8, 0; sample 50 -> timeout low next clock and duty ramps toward 50.
REQ-036 Disable and reset: enable=0 mid-ramp at duty=64 -> duty=0 and pwm_out=0 within 2 clocks; rst pulse mid-period -> all outputs at their REQ-028/029 values on the next clock.
REQ-037 Extremes: sample 255 -> pwm_out low exactly 1 clock per period at duty 255; no wrap occurs at duty 255 plus MAX_STEP.

Source files
------------

// File: rtl/pwm_slew_driver.sv
// pwm_slew_driver: PWM generator whose duty slews toward a sampled setpoint by
// at most MAX_STEP per PWM period, with a deadband on small setpoints and a
// watchdog that ramps the drive to zero when the sample stream stops.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       run enable; dropping it returns to IDLE with duty forced to 0
//   sample_in    8-bit setpoint sample
//   sample_valid one-cycle strobe qualifying sample_in
//   pwm_out      registered PWM drive, high while pwm_cnt < duty
//   duty         currently applied duty
//   at_target    combinational: duty equals the effective target
//   timeout      high while the watchdog has tripped (TIMEOUT state)
module pwm_slew_driver #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned MAX_STEP = 8,
  parameter int unsigned DEADBAND = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       pwm_out,
  output logic [7:0] duty,
  output logic       at_target,
  output logic       timeout
);

  localparam int unsigned DW    = 8;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DW-1:0]    STEP     = DW'(MAX_STEP);
  localparam logic [DW-1:0]    WD_LAST  = DW'(TIMEOUT - 1);
  localparam logic [DW-1:0]    CNT_LAST = DW'(255);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_TIMEOUT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [DW-1:0]    pwm_cnt;
  logic [DW-1:0]    target;
  logic [DW-1:0]    wd_cnt;

  logic             running;
  logic [DW-1:0]    eff_target;
  logic             tick;
  logic             pb;
  logic [DW-1:0]    diff;
  logic [DW-1:0]    step;
  logic [DW-1:0]    duty_slew;
  logic [DW-1:0]    capture_val;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a sample arriving on the expiring period keeps us in RUN
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (enable) state_next = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          state_next = S_IDLE;
        end else if (pb && !sample_valid && (wd_cnt == WD_LAST)) begin
          state_next = S_TIMEOUT;
        end
      end
      S_TIMEOUT: begin
        if (!enable) begin
          state_next = S_IDLE;
        end else if (sample_valid) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State decode: activity flag and the target the slew actually chases
  always_comb begin
    running    = 1'b0;
    eff_target = target;
    unique case (state)
      S_RUN:     running = 1'b1;
      S_TIMEOUT: begin
        running    = 1'b1;
        eff_target = '0;
      end
      default: begin
        running    = 1'b0;
        eff_target = target;
      end
    endcase
  end

  assign tick      = running && (div_cnt == DIV_LAST);
  assign pb        = tick && (pwm_cnt == CNT_LAST);
  assign at_target = (duty == eff_target);

  assign capture_val = (32'(sample_in) < DEADBAND) ? '0 : sample_in;

  // Bounded step toward the effective target; step never exceeds the gap,
  // so the result stays inside 0..255 without wider arithmetic
  always_comb begin
    diff      = '0;
    step      = '0;
    duty_slew = duty;
    if (eff_target >= duty) begin
      diff      = eff_target - duty;
      step      = (diff > STEP) ? STEP : diff;
      duty_slew = duty + step;
    end else begin
      diff      = duty - eff_target;
      step      = (diff > STEP) ? STEP : diff;
      duty_slew = duty - step;
    end
  end

  // Datapath; entering or sitting in IDLE clears everything on the same edge
  always_ff @(posedge clk) begin
    if (rst || (state_next == S_IDLE)) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
      duty    <= '0;
      target  <= '0;
      wd_cnt  <= '0;
      pwm_out <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        pwm_cnt <= pwm_cnt + DW'(1);
      end else if (running) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      pwm_out <= running && (pwm_cnt < duty);

      // Registered target means a coincident sample only affects the next pb
      if (pb) duty <= duty_slew;

      if (running && sample_valid) target <= capture_val;

      // Clear beats increment when a sample lands on the period boundary
      if (running && sample_valid) begin
        wd_cnt <= '0;
      end else if ((state == S_RUN) && pb) begin
        wd_cnt <= wd_cnt + DW'(1);
      end

      timeout <= (state_next == S_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_pwm_slew_driver.sv
// Testbench for pwm_slew_driver (CLK_DIV=1, MAX_STEP=8, DEADBAND=4, TIMEOUT=4).
// Expected duty values are queued when setpoints are driven and popped at
// every period boundary; pulse width per period is checked against the duty
// the bench expects for that period.
`timescale 1ns/1ps
module tb_pwm_slew_driver;

  localparam int unsigned CLK_DIV  = 1;
  localparam int unsigned MAX_STEP = 8;
  localparam int unsigned DEADBAND = 4;
  localparam int unsigned TIMEOUT  = 4;
  localparam int          PERIOD   = 256 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       pwm_out;
  logic [7:0] duty;
  logic       at_target;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int cur_duty = 0;
  int tf;
  int highs;
  int n;

  always #5 clk = ~clk;

  pwm_slew_driver #(
    .CLK_DIV (CLK_DIV),
    .MAX_STEP(MAX_STEP),
    .DEADBAND(DEADBAND),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .pwm_out     (pwm_out),
    .duty        (duty),
    .at_target   (at_target),
    .timeout     (timeout)
  );

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Expected per-period duty sequence for a slew from 'from' to 'to'
  task automatic push_ramp(input int from, input int to);
    int d;
    d = from;
    while (d != to) begin
      if (to > d) d = ((to - d) > MAX_STEP) ? d + MAX_STEP : to;
      else        d = ((d - to) > MAX_STEP) ? d - MAX_STEP : to;
      exp_q.push_back(d);
    end
  endtask

  // One full PWM period starting just after a boundary; optional sample at
  // cycle sv_at (255 lands on the boundary edge itself)
  task automatic run_period(input int sv_at, input int sv_val, output int to_first);
    int h;
    int want;
    h = 0;
    to_first = 0;
    for (int j = 0; j < PERIOD; j++) begin
      sample_valid = (j == sv_at);
      sample_in    = 8'(sv_val);
      step_clk();
      if (j == 0) to_first = int'(timeout);
      if (pwm_out) h++;
    end
    sample_valid = 1'b0;
    check("pwm_high_clocks", h, cur_duty);
    check("scoreboard_nonempty", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check("duty_at_pb", int'(duty), want);
      cur_duty = want;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_in = 8'd0;
    step_clk();
    step_clk();
    check("rst_duty", int'(duty), 0);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_at_target", int'(at_target), 1);
    rst = 1'b0;
    step_clk();
    check("idle_duty", int'(duty), 0);

    // Enable sampled on this edge; PWM counter starts at 0 afterwards
    enable = 1'b1;
    step_clk();
    cur_duty = 0;

    // Ramp-up to 100 with the setpoint streamed every period
    push_ramp(0, 100);
    check("ramp_len", exp_q.size(), 13);
    for (int i = 0; i < 13; i++) begin
      run_period(0, 100, tf);
      if (i == 11) check("at_target_mid_ramp", int'(at_target), 0);
    end
    check("ramp_final_duty", int'(duty), 100);
    check("ramp_at_target", int'(at_target), 1);

    // Sample 200 coincident with the boundary: old target used, wd cleared
    exp_q.push_back(100);
    run_period(255, 200, tf);
    exp_q.push_back(108);
    run_period(-1, 0, tf);
    check("wd_after_coincide_1", int'(timeout), 0);
    exp_q.push_back(116);
    run_period(-1, 0, tf);
    check("wd_after_coincide_2", int'(timeout), 0);
    exp_q.push_back(124);
    run_period(-1, 0, tf);
    check("wd_after_coincide_3", int'(timeout), 0);
    exp_q.push_back(132);
    run_period(-1, 0, tf);
    check("wd_trip_4th_pb", int'(timeout), 1);

    // Deadband sample 3 -> target 0; also leaves TIMEOUT
    push_ramp(132, 0);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      run_period(0, 3, tf);
      if (i == 0) check("timeout_clears_next_clk", tf, 0);
    end
    check("deadband_duty", int'(duty), 0);
    check("deadband_at_target", int'(at_target), 1);
    exp_q.push_back(4);
    run_period(0, 4, tf);
    check("edge_of_deadband_duty", int'(duty), 4);

    // Watchdog: settle at 40, then starve the sample stream
    push_ramp(4, 40);
    n = exp_q.size();
    for (int i = 0; i < n; i++) run_period(0, 40, tf);
    exp_q.push_back(40);
    run_period(-1, 0, tf);
    check("wd_pb2_timeout", int'(timeout), 0);
    exp_q.push_back(40);
    run_period(-1, 0, tf);
    check("wd_pb3_timeout", int'(timeout), 0);
    exp_q.push_back(40);
    run_period(-1, 0, tf);
    check("wd_pb4_timeout", int'(timeout), 1);
    check("timeout_at_target", int'(at_target), 0);
    push_ramp(40, 0);
    for (int i = 0; i < 5; i++) run_period(-1, 0, tf);
    check("timeout_held", int'(timeout), 1);
    check("timeout_zero_at_target", int'(at_target), 1);
    exp_q.push_back(8);
    run_period(0, 50, tf);
    check("recover_timeout_low", tf, 0);
    exp_q.push_back(16);
    run_period(0, 50, tf);
    push_ramp(16, 64);
    n = exp_q.size();
    for (int i = 0; i < n; i++) run_period(0, 64, tf);
    check("pre_disable_duty", int'(duty), 64);

    // Disable mid-period while driving high
    for (int j = 0; j < 40; j++) begin
      sample_valid = (j == 0);
      sample_in    = 8'd64;
      step_clk();
    end
    sample_valid = 1'b0;
    check("pre_disable_pwm", int'(pwm_out), 1);
    enable = 1'b0;
    step_clk();
    check("disable_pwm_1clk", int'(pwm_out), 0);
    step_clk();
    check("disable_duty", int'(duty), 0);
    check("disable_pwm", int'(pwm_out), 0);
    check("disable_at_target", int'(at_target), 1);

    // Extremes: full-scale setpoint, no wrap past 255
    enable = 1'b1;
    step_clk();
    cur_duty = 0;
    push_ramp(0, 255);
    check("full_ramp_len", exp_q.size(), 32);
    exp_q.push_back(255);
    n = exp_q.size();
    for (int i = 0; i < n; i++) run_period(0, 255, tf);
    check("full_scale_duty", int'(duty), 255);
    check("full_scale_at_target", int'(at_target), 1);

    // Reset mid-period while pwm_out is high
    for (int j = 0; j < 50; j++) step_clk();
    check("pre_reset_pwm", int'(pwm_out), 1);
    rst = 1'b1;
    enable = 1'b0;
    step_clk();
    check("midrst_duty", int'(duty), 0);
    check("midrst_pwm", int'(pwm_out), 0);
    check("midrst_timeout", int'(timeout), 0);
    check("midrst_at_target", int'(at_target), 1);
    rst = 1'b0;
    highs = 0;
    for (int j = 0; j < 20; j++) begin
      step_clk();
      if (pwm_out) highs++;
    end
    check("post_reset_no_pulse", highs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
